oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, CPU address whose write triggers a transfer.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, bus address driven during each OAM write cycle.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports cpu_clk_in and reset_in; all state changes on the rising edge of cpu_clk_in.
REQ-004 cpu_clk_in  in  1  CPU clock.
REQ-005 reset_in  in  1  synchronous active-high reset.
REQ-006 cpu_read_in  in  1  CPU read strobe.
REQ-007 cpu_write_in  in  1  CPU write strobe.
REQ-008 cpu_address_in  in  16  CPU address.
REQ-009 cpu_data_in  in  8  CPU write data.
REQ-010 ram_data_in  in  8  bus read data for the DMA address, valid one cycle after it is presented.
REQ-011 dma_address_out  out  16  DMA bus address.
REQ-012 dma_address_en_out  out  1  DMA owns the bus address.
REQ-013 dma_read_out  out  1  DMA bus read strobe.
REQ-014 dma_write_out  out  1  DMA bus write strobe to OAM_DATA_ADDR.
REQ-015 dma_data_out  out  8  byte written to OAM.
REQ-016 cpu_disable_out  out  1  CPU halt (drives RDY low).
REQ-017 dma_busy_out  out  1  transfer in progress.

Function
REQ-018 parity: 1-bit toggle flip-flop; 0 after reset; inverts every cycle; runs regardless of state.
REQ-019 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-020 Trigger: in IDLE, cpu_write_in=1 and cpu_address_in==DMA_REG_ADDR -> latch page=cpu_data_in, index=0, next state HALT.
REQ-021 Trigger is edge-free: one qualifying cycle = one transfer; cpu_read_in is ignored for trigger decode.
REQ-022 HALT: one cycle; next state ALIGN if parity==1 in HALT, else READ.
REQ-023 ALIGN: one cycle, no bus activity; next state READ.
REQ-024 READ: dma_address_out={page,index}; dma_address_en_out=1; dma_read_out=1; next state WRITE.
REQ-025 WRITE: capture ram_data_in into dma_data_out; dma_address_out=OAM_DATA_ADDR; dma_address_en_out=1; dma_write_out=1.
REQ-026 WRITE exit: index==255 -> IDLE; otherwise index+1 (8-bit), next state READ.
REQ-027 Addresses stay within the page; page 8'hFF ends at 16'hFFFF with no carry or wrap to 16'h0000.
REQ-028 cpu_disable_out and dma_busy_out SHALL be 1 in HALT, ALIGN, READ, WRITE and 0 in IDLE.
REQ-029 Total halt length SHALL be 513 cycles with parity 0 in HALT, 514 with parity 1.
REQ-030 Writes to DMA_REG_ADDR while not IDLE SHALL be ignored; page and index stay unchanged.
REQ-031 In IDLE, dma_address_en_out, dma_read_out, dma_write_out = 0 and dma_address_out = 16'h0000.
REQ-032 dma_data_out SHALL hold the last written byte until the next WRITE cycle or reset.
REQ-033 Strobes SHALL be registered outputs: glitch-free, and never both high in one cycle.

Reset
REQ-034 reset_in=1 SHALL force IDLE, parity=0, page=0, index=0, all outputs 0 on the next edge, including mid-transfer.
REQ-035 A trigger coincident with reset_in=1 SHALL be discarded.
REQ-036 The first trigger after reset release SHALL start a complete transfer from index 0.

Verification
REQ-037 Reset; write 8'h02 to 16'h4014 with parity 0 in HALT -> cpu_disable_out high 513 cycles; reads 16'h0200..16'h02FF in order; 256 writes to 16'h2004 with matching data.
REQ-038 Same trigger one cycle later (parity 1 in HALT) -> 514 cycles; exactly one ALIGN cycle with no strobes before the first READ.
REQ-039 Write 8'h05 to 16'h4014 during an active page-02 transfer -> ignored; all 256 reads stay in 16'h02xx; no second transfer afterwards.
REQ-040 Assert reset_in at index 100 -> all outputs 0 next cycle; a new trigger with 8'h03 reads from 16'h0300.
REQ-041 Trigger with 8'hFF -> last read address 16'hFFFF; no access to 16'h0000.
REQ-042 Writes to 16'h4015 and 16'h4016, and a read of 16'h4014 -> no transfer; cpu_disable_out stays 0.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the DMA register halts the CPU and copies
// one 256-byte page from the bus into OAM, one read/write pair per byte.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        cpu_clk_in,
    input  logic        reset_in,
    input  logic        cpu_read_in,
    input  logic        cpu_write_in,
    input  logic [15:0] cpu_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  ram_data_in,
    output logic [15:0] dma_address_out,
    output logic        dma_address_en_out,
    output logic        dma_read_out,
    output logic        dma_write_out,
    output logic [7:0]  dma_data_out,
    output logic        cpu_disable_out,
    output logic        dma_busy_out
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      r_state;
    logic        r_parity;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [15:0] r_addr;
    logic        r_addrEn;
    logic        r_readStb;
    logic        r_writeStb;
    logic        r_busy;
    logic [7:0]  r_lastByte;

    logic        w_trigger;
    logic [7:0]  w_nextIndex;
    logic        w_unusedRead;

    // The read strobe plays no part in decoding the trigger.
    assign w_unusedRead = cpu_read_in;
    assign w_trigger    = cpu_write_in && (cpu_address_in == DMA_REG_ADDR);
    assign w_nextIndex  = r_index + 8'd1;

    // Free-running parity bit used to align the first read to an even cycle.
    always_ff @(posedge cpu_clk_in) begin
        if (reset_in) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
        end
    end

    // Transfer sequencer; bus outputs are registered alongside the state they belong to.
    always_ff @(posedge cpu_clk_in) begin
        if (reset_in) begin
            r_state    <= IDLE;
            r_page     <= 8'h00;
            r_index    <= 8'h00;
            r_addr     <= 16'h0000;
            r_addrEn   <= 1'b0;
            r_readStb  <= 1'b0;
            r_writeStb <= 1'b0;
            r_busy     <= 1'b0;
            r_lastByte <= 8'h00;
        end else begin
            r_addr     <= 16'h0000;
            r_addrEn   <= 1'b0;
            r_readStb  <= 1'b0;
            r_writeStb <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page  <= cpu_data_in;
                        r_index <= 8'h00;
                        r_busy  <= 1'b1;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    if (r_parity) begin
                        r_state <= ALIGN;
                    end else begin
                        r_state   <= READ;
                        r_addr    <= {r_page, r_index};
                        r_addrEn  <= 1'b1;
                        r_readStb <= 1'b1;
                    end
                end
                ALIGN: begin
                    r_state   <= READ;
                    r_addr    <= {r_page, r_index};
                    r_addrEn  <= 1'b1;
                    r_readStb <= 1'b1;
                end
                READ: begin
                    r_state    <= WRITE;
                    r_addr     <= OAM_DATA_ADDR;
                    r_addrEn   <= 1'b1;
                    r_writeStb <= 1'b1;
                end
                WRITE: begin
                    r_lastByte <= ram_data_in;
                    if (r_index == 8'hFF) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_index   <= w_nextIndex;
                        r_state   <= READ;
                        r_addr    <= {r_page, w_nextIndex};
                        r_addrEn  <= 1'b1;
                        r_readStb <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The byte arrives from the bus during WRITE, so it is forwarded with the
    // write strobe and then held in r_lastByte until the next WRITE.
    assign dma_data_out       = (r_state == WRITE) ? ram_data_in : r_lastByte;
    assign dma_address_out    = r_addr;
    assign dma_address_en_out = r_addrEn;
    assign dma_read_out       = r_readStb;
    assign dma_write_out      = r_writeStb;
    assign cpu_disable_out    = r_busy;
    assign dma_busy_out       = r_busy;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma with a synchronous-RAM bus model.
module tb_oam_dma;

    logic        cpu_clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        cpu_read_in = 1'b0;
    logic        cpu_write_in = 1'b0;
    logic [15:0] cpu_address_in = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic [7:0]  ram_data_in;
    logic [15:0] dma_address_out;
    logic        dma_address_en_out;
    logic        dma_read_out;
    logic        dma_write_out;
    logic [7:0]  dma_data_out;
    logic        cpu_disable_out;
    logic        dma_busy_out;

    int compared = 0;
    int mismatched = 0;

    int busyLen, preRead, midQuiet, reads, writes, addrErr, dataErr, stbErr, extraBusy;
    logic [15:0] lastRead;

    oam_dma dut (
        .cpu_clk_in        (cpu_clk_in),
        .reset_in          (reset_in),
        .cpu_read_in       (cpu_read_in),
        .cpu_write_in      (cpu_write_in),
        .cpu_address_in    (cpu_address_in),
        .cpu_data_in       (cpu_data_in),
        .ram_data_in       (ram_data_in),
        .dma_address_out   (dma_address_out),
        .dma_address_en_out(dma_address_en_out),
        .dma_read_out      (dma_read_out),
        .dma_write_out     (dma_write_out),
        .dma_data_out      (dma_data_out),
        .cpu_disable_out   (cpu_disable_out),
        .dma_busy_out      (dma_busy_out)
    );

    // Free-running CPU clock.
    always #5 cpu_clk_in = ~cpu_clk_in;

    function automatic logic [7:0] ramModel(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Synchronous RAM: data for the presented address appears one cycle later.
    always @(posedge cpu_clk_in) ram_data_in <= ramModel(dma_address_out);

    // Global guard so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one CPU bus cycle starting at a falling edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] addr, input logic [7:0] data);
        cpu_write_in   = wr;
        cpu_read_in    = rd;
        cpu_address_in = addr;
        cpu_data_in    = data;
        @(negedge cpu_clk_in);
        cpu_write_in   = 1'b0;
        cpu_read_in    = 1'b0;
        cpu_address_in = 16'h0000;
        cpu_data_in    = 8'h00;
    endtask

    task automatic doReset();
        @(negedge cpu_clk_in);
        reset_in = 1'b1;
        repeat (2) @(negedge cpu_clk_in);
        reset_in = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag, input logic [7:0] expData);
        checkOutput({tag, "_disable"}, cpu_disable_out, 1'b0);
        checkOutput({tag, "_busy"}, dma_busy_out, 1'b0);
        checkOutput({tag, "_strobes"}, {dma_read_out, dma_write_out, dma_address_en_out}, 3'b000);
        checkOutput({tag, "_addr"}, dma_address_out, 16'h0000);
        checkOutput({tag, "_data"}, dma_data_out, expData);
    endtask

    // Observes a transfer cycle by cycle from the HALT cycle onward.
    task automatic runTransfer(input logic [7:0] page, input int injectAt, input int abortIdx);
        busyLen = 0; preRead = 0; midQuiet = 0; reads = 0; writes = 0;
        addrErr = 0; dataErr = 0; stbErr = 0; lastRead = 16'h0000;
        for (int c = 0; c < 700; c++) begin
            if (!cpu_disable_out) break;
            busyLen++;
            if (dma_busy_out !== 1'b1) stbErr++;
            if (dma_read_out && dma_write_out) stbErr++;
            if (dma_address_en_out !== (dma_read_out | dma_write_out)) stbErr++;
            if (!dma_read_out && !dma_write_out) begin
                if (reads == 0) preRead++;
                else midQuiet++;
            end
            if (dma_read_out) begin
                if (dma_address_out !== {page, reads[7:0]}) addrErr++;
                lastRead = dma_address_out;
                if (reads == abortIdx) begin
                    reset_in = 1'b1;
                    @(negedge cpu_clk_in);
                    break;
                end
                reads++;
            end
            if (dma_write_out) begin
                if (dma_address_out !== 16'h2004) addrErr++;
                if (dma_data_out !== ramModel(lastRead)) dataErr++;
                writes++;
            end
            if (c == injectAt) begin
                cpu_write_in = 1'b1; cpu_address_in = 16'h4014; cpu_data_in = 8'h05;
            end else if (c == injectAt + 1) begin
                cpu_write_in = 1'b0; cpu_address_in = 16'h0000; cpu_data_in = 8'h00;
            end
            @(negedge cpu_clk_in);
        end
    endtask

    task automatic checkTransfer(input string tag, input logic [7:0] page, input int expLen, input int expPre);
        checkOutput({tag, "_haltLen"}, busyLen, expLen);
        checkOutput({tag, "_preReadQuiet"}, preRead, expPre);
        checkOutput({tag, "_midQuiet"}, midQuiet, 0);
        checkOutput({tag, "_reads"}, reads, 256);
        checkOutput({tag, "_writes"}, writes, 256);
        checkOutput({tag, "_addrErr"}, addrErr, 0);
        checkOutput({tag, "_dataErr"}, dataErr, 0);
        checkOutput({tag, "_strobeErr"}, stbErr, 0);
        checkOutput({tag, "_lastRead"}, lastRead, {page, 8'hFF});
        checkIdleOutputs({tag, "_after"}, ramModel({page, 8'hFF}));
    endtask

    initial begin
        // Reset state
        doReset();
        checkIdleOutputs("reset", 8'h00);

        // Non-trigger accesses
        applyStimulus(1'b1, 1'b0, 16'h4015, 8'h02);
        checkOutput("wr4015_disable", cpu_disable_out, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h4016, 8'h02);
        checkOutput("wr4016_disable", cpu_disable_out, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h4014, 8'h02);
        checkOutput("rd4014_disable", cpu_disable_out, 1'b0);
        @(negedge cpu_clk_in);
        checkOutput("rd4014_busy", dma_busy_out, 1'b0);

        // Trigger with parity 0 in HALT: 513 cycles, no ALIGN
        doReset();
        @(negedge cpu_clk_in);
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'h02);
        runTransfer(8'h02, -1, -1);
        checkTransfer("p0", 8'h02, 513, 1);

        // Trigger with parity 1 in HALT: 514 cycles, one ALIGN
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'h02);
        runTransfer(8'h02, -1, -1);
        checkTransfer("p1", 8'h02, 514, 2);

        // Re-trigger during an active transfer is ignored
        doReset();
        @(negedge cpu_clk_in);
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'h02);
        runTransfer(8'h02, 50, -1);
        checkTransfer("retrig", 8'h02, 513, 1);
        extraBusy = 0;
        repeat (20) begin
            @(negedge cpu_clk_in);
            if (cpu_disable_out) extraBusy++;
        end
        checkOutput("retrig_noSecond", extraBusy, 0);

        // Reset mid-transfer at index 100, then a fresh page-03 transfer
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'h02);
        runTransfer(8'h02, -1, 100);
        checkOutput("abort_index", reads, 100);
        checkIdleOutputs("abort", 8'h00);
        reset_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'h03);
        runTransfer(8'h03, -1, -1);
        checkTransfer("page03", 8'h03, 514, 2);

        // Top page ends at FFFF without wrapping
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h4014, 8'hFF);
        runTransfer(8'hFF, -1, -1);
        checkTransfer("pageFF", 8'hFF, 514, 2);

        // Reset coincident with a trigger is discarded
        @(negedge cpu_clk_in);
        reset_in       = 1'b1;
        cpu_write_in   = 1'b1;
        cpu_address_in = 16'h4014;
        cpu_data_in    = 8'h07;
        @(negedge cpu_clk_in);
        reset_in       = 1'b0;
        cpu_write_in   = 1'b0;
        cpu_address_in = 16'h0000;
        cpu_data_in    = 8'h00;
        @(negedge cpu_clk_in);
        checkOutput("resetTrig_disable", cpu_disable_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
